segrw_arb2: RTL and testbench

//  Two-client arbiter for one segrw segment operator (4b addr, 8b data, d/e/v/b stream ports).
//  - Round-robin: picks one complete request bundle (addr+write[+dataW]) per issue.
//  - Holds it in a one-entry issue register and drives the segment's addr/write/dataW streams.
//  - Routes each read result on dataR back to the requester that issued it, via an in-order tag FIFO.

---
 rtl/segrw_arb2.sv | 235 +++++++++++++++++++++++
 tb/tb_segrw_arb2.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segrw_arb2.sv
// segrw_arb2: round-robin two-client arbiter for one segrw segment operator.
// Define SEGRW_ARB_STATS_EN to add grant and tag-stall counters.
module segrw_arb2 #(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] c0_addr_d,
    input  logic          c0_addr_v,
    output logic          c0_addr_b,
    input  logic          c0_write_d,
    input  logic          c0_write_v,
    output logic          c0_write_b,
    input  logic [DW-1:0] c0_dataW_d,
    input  logic          c0_dataW_v,
    output logic          c0_dataW_b,
    output logic [DW-1:0] c0_dataR_d,
    output logic          c0_dataR_v,
    input  logic          c0_dataR_b,
    input  logic [AW-1:0] c1_addr_d,
    input  logic          c1_addr_v,
    output logic          c1_addr_b,
    input  logic          c1_write_d,
    input  logic          c1_write_v,
    output logic          c1_write_b,
    input  logic [DW-1:0] c1_dataW_d,
    input  logic          c1_dataW_v,
    output logic          c1_dataW_b,
    output logic [DW-1:0] c1_dataR_d,
    output logic          c1_dataR_v,
    input  logic          c1_dataR_b,
    output logic [AW-1:0] seg_addr_d,
    output logic          seg_addr_e,
    output logic          seg_addr_v,
    input  logic          seg_addr_b,
    output logic          seg_write_d,
    output logic          seg_write_e,
    output logic          seg_write_v,
    input  logic          seg_write_b,
    output logic [DW-1:0] seg_dataW_d,
    output logic          seg_dataW_e,
    output logic          seg_dataW_v,
    input  logic          seg_dataW_b,
    input  logic [DW-1:0] seg_dataR_d,
    input  logic          seg_dataR_e,
    input  logic          seg_dataR_v,
    output logic          seg_dataR_b,
`ifdef SEGRW_ARB_STATS_EN
    output logic [15:0]   c0_grants,
    output logic [15:0]   c1_grants,
    output logic [15:0]   stall_cyc,
`endif
    output logic          err
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] TAG_FULL = CW'(TAG_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [AW-1:0]        iss_addr_q, iss_addr_d;
    logic                 iss_write_q, iss_write_d;
    logic [DW-1:0]        iss_data_q, iss_data_d;
    logic                 iss_id_q, iss_id_d;
    logic                 pend_a_q, pend_a_d;
    logic                 pend_w_q, pend_w_d;
    logic                 pend_dw_q, pend_dw_d;
    logic [TAG_DEPTH-1:0] tags_q, tags_d;
    logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic rdy0, rdy1, el0, el1, full, empty;
    logic grant, win, head, push, pop, retire;
    logic xa, xw, xd, head_b;
    logic unused_e;

    assign unused_e = seg_dataR_e;

    always_comb begin
        rdy0 = c0_addr_v & c0_write_v & (~c0_write_d | c0_dataW_v);
        rdy1 = c1_addr_v & c1_write_v & (~c1_write_d | c1_dataW_v);
        full = (cnt_q == TAG_FULL);
        empty = (cnt_q == '0);
        el0 = rdy0 & ~(~c0_write_d & full);
        el1 = rdy1 & ~(~c1_write_d & full);
        grant = (state_q == IDLE) & (el0 | el1);
        // On a tie the client that did not win last time goes first
        win = (el0 & el1) ? ~last_q : el1;
        xa = pend_a_q & ~seg_addr_b;
        xw = pend_w_q & ~seg_write_b;
        xd = pend_dw_q & ~seg_dataW_b;
        retire = (state_q == ISSUE) & ~(pend_a_q & ~xa)
               & ~(pend_w_q & ~xw) & ~(pend_dw_q & ~xd);
        push = retire & ~iss_write_q;
        head = tags_q[rd_q];
        head_b = head ? c1_dataR_b : c0_dataR_b;
        pop = seg_dataR_v & ~empty & ~head_b;

        state_d = state_q;
        last_d = last_q;
        iss_addr_d = iss_addr_q;
        iss_write_d = iss_write_q;
        iss_data_d = iss_data_q;
        iss_id_d = iss_id_q;
        pend_a_d = pend_a_q & ~xa;
        pend_w_d = pend_w_q & ~xw;
        pend_dw_d = pend_dw_q & ~xd;
        tags_d = tags_q;
        rd_d = rd_q;
        wr_d = wr_q;
        cnt_d = cnt_q;
        err_d = err_q | (seg_dataR_v & empty);

        if (grant) begin
            state_d = ISSUE;
            last_d = win;
            iss_id_d = win;
            iss_addr_d = win ? c1_addr_d : c0_addr_d;
            iss_write_d = win ? c1_write_d : c0_write_d;
            iss_data_d = win ? c1_dataW_d : c0_dataW_d;
            pend_a_d = 1'b1;
            pend_w_d = 1'b1;
            pend_dw_d = iss_write_d;
        end else if (retire) begin
            state_d = IDLE;
        end

        if (push) begin
            tags_d[wr_q] = iss_id_q;
            wr_d = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            iss_addr_q <= '0;
            iss_write_q <= 1'b0;
            iss_data_q <= '0;
            iss_id_q <= 1'b0;
            pend_a_q <= 1'b0;
            pend_w_q <= 1'b0;
            pend_dw_q <= 1'b0;
            tags_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            iss_addr_q <= iss_addr_d;
            iss_write_q <= iss_write_d;
            iss_data_q <= iss_data_d;
            iss_id_q <= iss_id_d;
            pend_a_q <= pend_a_d;
            pend_w_q <= pend_w_d;
            pend_dw_q <= pend_dw_d;
            tags_q <= tags_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign c0_addr_b = ~(grant & ~win);
    assign c0_write_b = ~(grant & ~win);
    assign c0_dataW_b = ~(grant & ~win & c0_write_d);
    assign c1_addr_b = ~(grant & win);
    assign c1_write_b = ~(grant & win);
    assign c1_dataW_b = ~(grant & win & c1_write_d);

    assign seg_addr_d = iss_addr_q;
    assign seg_addr_e = 1'b0;
    assign seg_addr_v = pend_a_q;
    assign seg_write_d = iss_write_q;
    assign seg_write_e = 1'b0;
    assign seg_write_v = pend_w_q;
    assign seg_dataW_d = iss_data_q;
    assign seg_dataW_e = 1'b0;
    assign seg_dataW_v = pend_dw_q;

    // Results with no outstanding tag are drained so the segment never wedges
    assign seg_dataR_b = empty ? ~seg_dataR_v : head_b;
    assign c0_dataR_d = seg_dataR_d;
    assign c1_dataR_d = seg_dataR_d;
    assign c0_dataR_v = seg_dataR_v & ~empty & ~head;
    assign c1_dataR_v = seg_dataR_v & ~empty & head;
    assign err = err_q;

`ifdef SEGRW_ARB_STATS_EN
    logic [15:0] g0_q, g0_d, g1_q, g1_d, st_q, st_d;
    logic        stall;

    always_comb begin
        stall = (state_q == IDLE) & full
              & ((rdy0 & ~c0_write_d) | (rdy1 & ~c1_write_d));
        g0_d = g0_q;
        g1_d = g1_q;
        st_d = st_q;
        if (grant & ~win & (g0_q != 16'hFFFF)) g0_d = g0_q + 16'd1;
        if (grant & win & (g1_q != 16'hFFFF)) g1_d = g1_q + 16'd1;
        if (stall & (st_q != 16'hFFFF)) st_d = st_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            g0_q <= '0;
            g1_q <= '0;
            st_q <= '0;
        end else begin
            g0_q <= g0_d;
            g1_q <= g1_d;
            st_q <= st_d;
        end
    end

    assign c0_grants = g0_q;
    assign c1_grants = g1_q;
    assign stall_cyc = st_q;
`endif
endmodule

// File: tb/tb_segrw_arb2.sv
// tb_segrw_arb2: random clients and segment against a transaction-level
// model of grants, issue streams, tag routing and the err flag.
module tb_segrw_arb2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TD = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          av[2], wv[2], wd[2], dv[2], cb[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] dd[2];
    logic          sab, swb, sdb, rv;
    logic [DW-1:0] rdd;

    logic          c0_addr_b, c0_write_b, c0_dataW_b, c0_dataR_v;
    logic          c1_addr_b, c1_write_b, c1_dataW_b, c1_dataR_v;
    logic [DW-1:0] c0_dataR_d, c1_dataR_d;
    logic [AW-1:0] seg_addr_d;
    logic          seg_addr_e, seg_addr_v;
    logic          seg_write_d, seg_write_e, seg_write_v;
    logic [DW-1:0] seg_dataW_d;
    logic          seg_dataW_e, seg_dataW_v, seg_dataR_b, err;
`ifdef SEGRW_ARB_STATS_EN
    logic [15:0]   c0_grants, c1_grants, stall_cyc;
`endif

    segrw_arb2 #(.AW(AW), .DW(DW), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset(reset),
        .c0_addr_d(ad[0]), .c0_addr_v(av[0]), .c0_addr_b(c0_addr_b),
        .c0_write_d(wd[0]), .c0_write_v(wv[0]), .c0_write_b(c0_write_b),
        .c0_dataW_d(dd[0]), .c0_dataW_v(dv[0]), .c0_dataW_b(c0_dataW_b),
        .c0_dataR_d(c0_dataR_d), .c0_dataR_v(c0_dataR_v), .c0_dataR_b(cb[0]),
        .c1_addr_d(ad[1]), .c1_addr_v(av[1]), .c1_addr_b(c1_addr_b),
        .c1_write_d(wd[1]), .c1_write_v(wv[1]), .c1_write_b(c1_write_b),
        .c1_dataW_d(dd[1]), .c1_dataW_v(dv[1]), .c1_dataW_b(c1_dataW_b),
        .c1_dataR_d(c1_dataR_d), .c1_dataR_v(c1_dataR_v), .c1_dataR_b(cb[1]),
        .seg_addr_d(seg_addr_d), .seg_addr_e(seg_addr_e),
        .seg_addr_v(seg_addr_v), .seg_addr_b(sab),
        .seg_write_d(seg_write_d), .seg_write_e(seg_write_e),
        .seg_write_v(seg_write_v), .seg_write_b(swb),
        .seg_dataW_d(seg_dataW_d), .seg_dataW_e(seg_dataW_e),
        .seg_dataW_v(seg_dataW_v), .seg_dataW_b(sdb),
        .seg_dataR_d(rdd), .seg_dataR_e(1'b0), .seg_dataR_v(rv),
        .seg_dataR_b(seg_dataR_b),
`ifdef SEGRW_ARB_STATS_EN
        .c0_grants(c0_grants), .c1_grants(c1_grants), .stall_cyc(stall_cyc),
`endif
        .err(err)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference: one bundle in flight, in-order tag list, two memories
    bit            busy, pa, pw, pd, b_w, err_m;
    int            last, b_id;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    int            tagq[$];
    logic [DW-1:0] segq[$], expq0[$], expq1[$];
    logic [DW-1:0] refmem[16], smem[16];

    bit            rq[2], rw[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2];
    int            pv, pbp, pret, pcb, preq, prd[2];
    bit            inj;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic step();
        bit rdy[2], el[2];
        bit full, gnt, xa, xw, xd, eb, was_empty;
        int win, h;
        logic [DW-1:0] got, ex;
        @(negedge clock);
        for (int n = 0; n < 2; n++) begin
            av[n] = rq[n] && roll(pv);
            wv[n] = rq[n] && roll(pv);
            dv[n] = rq[n] && roll(pv);
            wd[n] = rw[n];
            ad[n] = ra[n];
            dd[n] = rd[n];
            cb[n] = roll(pcb);
        end
        sab = roll(pbp);
        swb = roll(pbp);
        sdb = roll(pbp);
        rdd = DW'($urandom_range(255));
        rv = 1'b0;
        if (segq.size() > 0 && roll(pret)) begin
            rv = 1'b1;
            rdd = segq[0];
        end else if (inj && tagq.size() == 0 && roll(40)) begin
            rv = 1'b1;
        end
        #1;
        for (int n = 0; n < 2; n++) begin
            rdy[n] = av[n] && wv[n] && (!wd[n] || dv[n]);
            full = (tagq.size() == TD);
            el[n] = rdy[n] && !(!wd[n] && full);
        end
        gnt = !busy && (el[0] || el[1]);
        win = (el[0] && el[1]) ? 1 - last : (el[1] ? 1 : 0);
        chk("c0_addr_b", c0_addr_b, !(gnt && win == 0));
        chk("c1_addr_b", c1_addr_b, !(gnt && win == 1));
        chk("c0_write_b", c0_write_b, !(gnt && win == 0));
        chk("c1_write_b", c1_write_b, !(gnt && win == 1));
        chk("c0_dataW_b", c0_dataW_b, !(gnt && win == 0 && wd[0]));
        chk("c1_dataW_b", c1_dataW_b, !(gnt && win == 1 && wd[1]));
        chk("seg_addr_v", seg_addr_v, pa);
        chk("seg_write_v", seg_write_v, pw);
        chk("seg_dataW_v", seg_dataW_v, pd);
        if (pa) chk("seg_addr_d", seg_addr_d, b_addr);
        if (pw) chk("seg_write_d", seg_write_d, b_w);
        if (pd) chk("seg_dataW_d", seg_dataW_d, b_data);
        chk("seg_e", {seg_addr_e, seg_write_e, seg_dataW_e}, 0);

        was_empty = (tagq.size() == 0);
        if (was_empty) begin
            eb = !rv;
            chk("c0_dataR_v", c0_dataR_v, 0);
            chk("c1_dataR_v", c1_dataR_v, 0);
        end else begin
            h = tagq[0];
            eb = cb[h];
            chk("c0_dataR_v", c0_dataR_v, rv && h == 0);
            chk("c1_dataR_v", c1_dataR_v, rv && h == 1);
            if (rv && !eb) begin
                got = h ? c1_dataR_d : c0_dataR_d;
                ex = h ? expq1.pop_front() : expq0.pop_front();
                chk("dataR_d", got, ex);
                void'(tagq.pop_front());
                void'(segq.pop_front());
            end
        end
        chk("seg_dataR_b", seg_dataR_b, eb);
        chk("err", err, err_m);
        err_m = err_m | (rv && was_empty);

        xa = pa && !sab;
        xw = pw && !swb;
        xd = pd && !sdb;
        if (busy && !(pa && !xa) && !(pw && !xw) && !(pd && !xd)) begin
            busy = 0;
            if (b_w) smem[b_addr] = b_data;
            else begin
                segq.push_back(smem[b_addr]);
                tagq.push_back(b_id);
            end
        end
        pa = pa && !xa;
        pw = pw && !xw;
        pd = pd && !xd;
        if (gnt) begin
            busy = 1;
            b_id = win;
            b_addr = ra[win];
            b_w = rw[win];
            b_data = rd[win];
            pa = 1;
            pw = 1;
            pd = rw[win];
            last = win;
            if (rw[win]) refmem[ra[win]] = rd[win];
            else if (win == 1) expq1.push_back(refmem[ra[win]]);
            else expq0.push_back(refmem[ra[win]]);
            rq[win] = 0;
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            step();
            for (int n = 0; n < 2; n++) begin
                if (!rq[n] && roll(preq)) begin
                    rq[n] = 1;
                    rw[n] = !roll(prd[n]);
                    ra[n] = AW'($urandom_range(15));
                    rd[n] = DW'($urandom_range(255));
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            av[n] = 0; wv[n] = 0; dv[n] = 0; cb[n] = 0;
            rq[n] = 0;
        end
        sab = 1; swb = 1; sdb = 1; rv = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        busy = 0; pa = 0; pw = 0; pd = 0;
        last = 1; err_m = 0;
        tagq.delete(); segq.delete();
        expq0.delete(); expq1.delete();
        refmem = smem;
    endtask

    task automatic knobs(input int v, bp, ret, c_b, req, r0, r1);
        pv = v; pbp = bp; pret = ret; pcb = c_b; preq = req;
        prd[0] = r0; prd[1] = r1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            smem[i] = '0;
            refmem[i] = '0;
        end
        inj = 0;
        ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
        rw[0] = 0; rw[1] = 0;
        rdd = '0;
        for (int n = 0; n < 2; n++) begin
            ad[n] = '0; dd[n] = '0; wd[n] = 0;
        end
        do_reset();
        run(2);

        knobs(100, 0, 100, 0, 0, 0, 0);
        rq[0] = 1; rw[0] = 1; ra[0] = 4'd3; rd[0] = 8'hA5;
        run(4);
        rq[0] = 1; rw[0] = 0; ra[0] = 4'd3;
        run(8);

        knobs(100, 0, 100, 0, 100, 50, 50);
        run(80);

        knobs(100, 0, 0, 0, 100, 0, 100);
        run(40);
        knobs(100, 0, 60, 20, 100, 0, 100);
        run(60);

        knobs(85, 30, 50, 30, 80, 50, 50);
        run(400);

        knobs(90, 70, 40, 50, 90, 40, 60);
        run(200);
        knobs(100, 80, 30, 30, 100, 50, 50);
        run(37);
        do_reset();
        run(3);

        knobs(90, 20, 100, 0, 0, 50, 50);
        run(30);
        inj = 1;
        run(30);
        inj = 0;
        run(5);
        do_reset();
        knobs(85, 30, 50, 30, 80, 50, 50);
        run(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
